// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO family.
// Holds the parameter-legality rule so every FIFO variant enforces the same limits.
package sync_fifo_param_pkg;

    function automatic logic fifo_params_legal(
        input int data_width,
        input int depth,
        input int af_level,
        input int ae_level
    );
        logic ok_s;
        ok_s = (data_width >= 32'sd1) &&
               (depth >= 32'sd2) &&
               ((depth & (depth - 32'sd1)) == 32'sd0) &&
               (af_level >= 32'sd0) && (af_level <= depth) &&
               (ae_level >= 32'sd0) && (ae_level <= depth - 32'sd1);
        return ok_s;
    endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous read, never reset.
module sync_fifo_param_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable thresholds,
// overflow/underflow pulses and a selectable registered or FWFT read port.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    read_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);
    localparam logic [CW-1:0] ONE  = CW'(1'b1);

    if (!fifo_params_legal(DATA_WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal parameter combination");
    end

    logic [CW-1:0]         wr_ptr_r, rd_ptr_r, count_r;
    logic                  overflow_r, underflow_r;
    logic                  full_s, empty_s, rd_acc_s, wr_acc_s;
    logic [DATA_WIDTH-1:0] mem_rd_s;

    // Extra pointer MSB separates a full FIFO from an empty one at equal indices.
    assign full_s   = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
    assign empty_s  = (wr_ptr_r == rd_ptr_r);
    assign rd_acc_s = read_en & ~empty_s;
    assign wr_acc_s = write_en & (~full_s | rd_acc_s);

    sync_fifo_param_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc_s),
        .wr_idx  (wr_ptr_r[AW-1:0]),
        .wr_data (data_in),
        .rd_idx  (rd_ptr_r[AW-1:0]),
        .rd_data (mem_rd_s)
    );

    // Pointers, occupancy counter and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {CW{1'b0}};
            rd_ptr_r    <= {CW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ONE;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + ONE;
                2'b01:   count_r <= count_r - ONE;
                default: count_r <= count_r;
            endcase
            overflow_r  <= write_en & ~wr_acc_s;
            underflow_r <= read_en & empty_s;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is visible whenever the FIFO holds data; zero otherwise.
        assign data_out  = empty_s ? {DATA_WIDTH{1'b0}} : mem_rd_s;
        assign valid_out = ~empty_s;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] data_out_r;
        logic                  valid_out_r;

        // Registered read port; data_out keeps its last word between reads
        always_ff @(posedge clk) begin
            if (rst) begin
                data_out_r  <= {DATA_WIDTH{1'b0}};
                valid_out_r <= 1'b0;
            end else begin
                valid_out_r <= rd_acc_s;
                if (rd_acc_s) begin
                    data_out_r <= mem_rd_s;
                end
            end
        end

        assign data_out  = data_out_r;
        assign valid_out = valid_out_r;
    end

    assign full         = full_s;
    assign empty        = empty_s;
    assign count        = count_r;
    assign almost_full  = (count_r >= AF_L);
    assign almost_empty = (count_r <= AE_L);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a registered-read instance for the main
// sequences and a first-word-fall-through instance for the FWFT behaviour.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic          clk;
    logic          rst;
    logic          write_en, read_en;
    logic [DW-1:0] data_in, data_out;
    logic          valid_out, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]    count;

    logic          f_we, f_re;
    logic [DW-1:0] f_din, f_dout;
    logic          f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0]    f_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_q   [$];

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .data_in(data_in), .read_en(read_en),
        .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .write_en(f_we), .data_in(f_din), .read_en(f_re),
        .data_out(f_dout), .valid_out(f_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock on the registered-read instance; model decides acceptance from its own queue.
    task automatic cycle(input logic we, input logic [DW-1:0] din, input logic re);
        logic rd_acc, wr_acc, exp_ovf, exp_udf;
        int   occ;
        write_en = we;
        data_in  = din;
        read_en  = re;
        rd_acc   = re && (model_q.size() != 0);
        wr_acc   = we && ((model_q.size() != DEPTH) || rd_acc);
        exp_ovf  = we && !wr_acc;
        exp_udf  = re && (model_q.size() == 0);
        if (rd_acc) exp_q.push_back(model_q.pop_front());
        if (wr_acc) model_q.push_back(din);
        occ = model_q.size();
        @(posedge clk);
        #1;
        check("count",        32'(count),        32'(occ));
        check("full",         32'(full),         32'(occ == DEPTH));
        check("empty",        32'(empty),        32'(occ == 0));
        check("almost_full",  32'(almost_full),  32'(occ >= AFL));
        check("almost_empty", 32'(almost_empty), 32'(occ <= AEL));
        check("overflow",     32'(overflow),     32'(exp_ovf));
        check("underflow",    32'(underflow),    32'(exp_udf));
        check("valid_out",    32'(valid_out),    32'(rd_acc));
        if (valid_out) begin
            if (exp_q.size() == 0) check("spurious_valid", 32'(1'b1), 32'(1'b0));
            else                   check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; write_en = 1'b0; read_en = 1'b0; f_we = 1'b0; f_re = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        exp_q.delete();
        check("rst_count",     32'(count),        32'd0);
        check("rst_empty",     32'(empty),        32'd1);
        check("rst_full",      32'(full),         32'd0);
        check("rst_ae",        32'(almost_empty), 32'd1);
        check("rst_af",        32'(almost_full),  32'd0);
        check("rst_valid",     32'(valid_out),    32'd0);
        check("rst_data",      32'(data_out),     32'd0);
        check("rst_ovf_udf",   32'({overflow, underflow}), 32'd0);
        check("rst_fwft_valid", 32'(f_valid),     32'd0);
        check("rst_fwft_data",  32'(f_dout),      32'd0);
    endtask

    initial begin
        rst = 1'b1; write_en = 1'b0; read_en = 1'b0; data_in = 8'h00;
        f_we = 1'b0; f_re = 1'b0; f_din = 8'h00;
        do_reset();

        // 1: fill 0x01..0x10, then an overflowing write of 0xFF
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hFF, 1'b0);

        // 2: drain in order, then an underflowing read that must leave data_out alone
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check("hold_after_underflow", 32'(data_out), 32'h10);
        check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 3: simultaneous write/read while full
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
        check("last_read_is_AA", 32'(data_out), 32'hAA);

        // 4: alternating bursts of 5 across the pointer wrap
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
        end
        check("wrap_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 6: reset in the middle of a 9-deep fill, then one fresh word
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        do_reset();
        cycle(1'b1, 8'h77, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        check("post_reset_word", 32'(data_out), 32'h77);
        cycle(1'b0, 8'h00, 1'b1);

        // 5: FWFT instance
        f_we = 1'b1; f_din = 8'h5C;
        @(posedge clk); #1;
        f_we = 1'b0;
        check("fwft_valid",  32'(f_valid), 32'd1);
        check("fwft_data",   32'(f_dout),  32'h5C);
        check("fwft_count",  32'(f_count), 32'd1);
        f_re = 1'b1;
        @(posedge clk); #1;
        f_re = 1'b0;
        check("fwft_pop_valid", 32'(f_valid), 32'd0);
        check("fwft_pop_empty", 32'(f_empty), 32'd1);
        check("fwft_pop_udf",   32'(f_udf),   32'd0);
        f_we = 1'b1; f_din = 8'hA1;
        @(posedge clk); #1;
        f_din = 8'hA2;
        @(posedge clk); #1;
        f_we = 1'b0;
        check("fwft_head_first", 32'(f_dout), 32'hA1);
        f_re = 1'b1;
        @(posedge clk); #1;
        check("fwft_head_second", 32'(f_dout), 32'hA2);
        @(posedge clk); #1;
        check("fwft_drained", 32'(f_valid), 32'd0);
        @(posedge clk); #1;
        f_re = 1'b0;
        check("fwft_underflow", 32'(f_udf), 32'd1);
        check("fwft_ovf_quiet", 32'(f_ovf), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
